image_loader_mc: RTL and testbench
==================================

# image_loader_mc

Parametrised multi-channel image loader, successor to the single-channel 784-byte loader. It consumes the routed UART byte stream once weights are loaded and validates the start marker instead of dropping it blindly. It assembles 1- or 2-byte little-endian pixels and de-interleaves pixel-interleaved channels into channel-planar memory. Frames go into a ping-pong pair of buffer banks, so inference reads one bank while the next image loads. It sits between `uart_router` and the input image RAM.

## Interface
- `CHANNELS`, default 1: channels per pixel, 1..4.
- `IMG_PIXELS`, default 784: pixels per channel.
- `PIX_BYTES`, default 1: bytes per pixel sample, 1 or 2, little-endian.
- `START_MARK`, default 8'h66: required first byte of a frame.
- `END_MARK1`, default 8'h66: first trailer byte.
- `END_MARK2`, default 8'hBB: second trailer byte.
- `TIMEOUT_CYC`, default 1_000_000: idle cycles tolerated between bytes inside a frame.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `weights_loaded`, in, 1: bytes are ignored while low.
- `rx_data`, in, 8: routed byte.
- `rx_ready`, in, 1: one-cycle strobe qualifying `rx_data`.
- `img_consumed`, in, 1: one-cycle strobe; inference has released the bank given by `rd_bank`.
- `wr_en`, out, 1: write strobe.
- `wr_bank`, out, 1: bank targeted by the write.
- `wr_addr`, out, clog2(CHANNELS*IMG_PIXELS): planar address.
- `wr_data`, out, 8*PIX_BYTES: pixel sample.
- `image_loaded`, out, 1: one-cycle pulse when a frame completes.
- `rd_bank`, out, 1: bank holding the newest complete frame.
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted.
- `err_code`, out, 2: reason for the last abort. 0 none, 1 bad end marker, 2 timeout, 3 overrun. Holds until the next abort or reset.

## Operation
- Frame size: F = CHANNELS*IMG_PIXELS samples, which is B = F*PIX_BYTES payload bytes.
- States: IDLE, DATA, END1, END2, DONE, ERR.
- IDLE:
  - Bytes accepted only when `weights_loaded` is high.
  - `START_MARK` with a free bank → DATA, counters cleared.
  - Any other byte is discarded and the state stays IDLE. This is not an error.
  - `START_MARK` while both banks hold unconsumed frames → ERR, code 3.
- DATA:
  - Each byte is shifted into the pixel assembler; the first byte is the LSB.
  - On the last byte of a sample, a write is issued. `ch` cycles 0..CHANNELS-1, and `pix` increments after `ch` wraps.
  - Write address is `ch*IMG_PIXELS + pix`. This uses incremental offset registers; no multiplier.
  - After byte B → END1.
- END1: byte equal to `END_MARK1` → END2; any other byte → ERR, code 1.
- END2: byte equal to `END_MARK2` → DONE; any other byte → ERR, code 1. The trailer is positional, so payload bytes equal to the markers are legal data.
- DONE (one cycle):
  - `image_loaded` pulses.
  - `rd_bank` takes the value of `wr_bank`.
  - The bank is marked full and `wr_bank` toggles.
  - → IDLE.
- ERR (one cycle):
  - `frame_err` pulses and `err_code` is updated.
  - The partially written bank stays empty and `wr_bank` is unchanged.
  - → IDLE.
- Timeout: in DATA, END1 or END2, a counter is cleared on every `rx_ready` and increments otherwise. When it reaches `TIMEOUT_CYC` → ERR, code 2.
- Bank occupancy: two full flags. `img_consumed` clears the flag of `rd_bank`. If a set and a clear hit the same flag in the same cycle, the set wins.
- `weights_loaded` falling mid-frame: the frame aborts silently to IDLE, with no `frame_err`.

## Timing
- Reset (`rst_n` low at a clock edge): all outputs are 0, the state is IDLE, and both bank flags are cleared.
- Write latency: `wr_en`/`wr_addr`/`wr_data` are registered and asserted the cycle after the `rx_ready` that completes the sample. `wr_en` is a one-cycle pulse.
- `image_loaded` pulses two cycles after the `rx_ready` carrying `END_MARK2`. `rd_bank` is valid in the same cycle as the pulse.
- Back-to-back `rx_ready` on consecutive cycles must be sustained without loss.
- A `START_MARK` arriving in the DONE or ERR cycle is lost. The router guarantees a gap of at least 2 cycles between frames.
- When `rx_ready` and a timeout expiry coincide, the byte wins and the counter clears.

## Structure
- Shared package `loader_pkg`:
  - State encodings.
  - `err_code` constants (`ERR_NONE`, `ERR_END`, `ERR_TMO`, `ERR_OVR`).
  - Default marker values.
- Natural sub-module: `pix_deinterleave`. It contains the sample assembler plus the `ch`/`pix` counters and offset registers, and outputs addr/data/valid. The FSM, timeout counter and bank flags stay in the top module.

## Test plan
- Defaults (1 channel, 1-byte pixels): stream 0x66, bytes 0..783 mod 256, 0x66, 0xBB.
  - Expect 784 writes, address n carrying data n mod 256, all with `wr_bank`=0.
  - Expect `image_loaded` once, then `rd_bank`=0 and `wr_bank`=1.
- CHANNELS=3, PIX_BYTES=2, IMG_PIXELS=4: stream 24 bytes encoding sample value 0x0100*c+p.
  - Expect address c*4+p to carry data 0x0100*c+p.
- Payload containing 0x66, 0xBB at bytes 100/101:
  - Expect no early termination.
  - Then a trailer of 0x66, 0x00 → `frame_err` with `err_code`=1 and `rd_bank` unchanged.
- Stall 1,000,000 idle cycles after byte 300 → `frame_err` with `err_code`=2.
  - A following valid frame loads into the same bank.
- Two good frames without `img_consumed`, then a third 0x66 → `err_code`=3 with no writes.
  - Pulse `img_consumed`, then a third frame succeeds into bank 0.
- Drive `rst_n` low at byte 400 → all outputs 0 the next cycle.
  - Garbage bytes before 0x66 are ignored, and `weights_loaded`=0 blocks all writes.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the multi-channel image loader.
// Contents: frame FSM state encoding, err_code values and default marker bytes.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StEnd1,
    StEnd2,
    StDone,
    StErr
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_END  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] DEF_START_MARK = 8'h66;
  localparam logic [7:0] DEF_END_MARK1  = 8'h66;
  localparam logic [7:0] DEF_END_MARK2  = 8'hBB;

endpackage

// File: rtl/pix_deinterleave.sv
// Pixel assembler and channel de-interleaver.
// Collects PIX_BYTES little-endian bytes into one sample and maps the pixel-interleaved
// stream onto a channel-planar address (ch*IMG_PIXELS + pix) with an offset register.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : restart counters at the start of a frame
//   i_valid/i_byte : one payload byte
//   o_valid        : registered one-cycle write strobe
//   o_addr/o_data  : registered planar address and assembled sample
module pix_deinterleave #(
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IMG_PIXELS = 784,
  parameter int unsigned PIX_BYTES  = 1,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [7:0]    i_byte,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          w_samp_done;
  logic [DW-1:0] w_sample;

  logic [CW-1:0] r_ch;
  logic [AW-1:0] r_pix;
  logic [AW-1:0] r_off;   // ch*IMG_PIXELS, built by repeated addition
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  if (PIX_BYTES == 1) begin : g_one_byte
    assign w_samp_done = i_valid;
    assign w_sample    = i_byte;
  end else begin : g_two_byte
    logic       r_half;   // high while waiting for the MSB
    logic [7:0] r_lo;
    always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
        r_half <= 1'b0;
        r_lo   <= 8'h00;
      end else if (i_valid) begin
        r_half <= ~r_half;
        r_lo   <= i_byte;
      end
    end
    assign w_samp_done = i_valid & r_half;
    assign w_sample    = {i_byte, r_lo};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ch    <= '0;
      r_pix   <= '0;
      r_off   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_samp_done;
      if (i_clear) begin
        r_ch  <= '0;
        r_pix <= '0;
        r_off <= '0;
      end else if (w_samp_done) begin
        r_addr <= r_off + r_pix;
        r_data <= w_sample;
        if (r_ch == CW'(CHANNELS - 1)) begin
          r_ch  <= '0;
          r_off <= '0;
          r_pix <= r_pix + 1'b1;
        end else begin
          r_ch  <= r_ch + 1'b1;
          r_off <= r_off + AW'(IMG_PIXELS);
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/image_loader_mc.sv
// Multi-channel ping-pong image loader.
// Validates the start marker, streams the payload through pix_deinterleave into the
// current write bank, checks the two-byte trailer and flips banks on success.
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_weights_loaded          : bytes ignored while low; falling mid-frame aborts silently
//   i_rx_data/i_rx_ready      : routed byte stream
//   i_img_consumed            : inference released bank o_rd_bank
//   o_wr_en/bank/addr/data    : planar RAM write port
//   o_image_loaded, o_rd_bank : frame-complete pulse, newest complete bank
//   o_frame_err, o_err_code   : abort pulse and sticky abort reason
module image_loader_mc
  import loader_pkg::*;
#(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned IMG_PIXELS  = 784,
  parameter int unsigned PIX_BYTES   = 1,
  parameter logic [7:0]  START_MARK  = DEF_START_MARK,
  parameter logic [7:0]  END_MARK1   = DEF_END_MARK1,
  parameter logic [7:0]  END_MARK2   = DEF_END_MARK2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  localparam int unsigned AW = (CHANNELS * IMG_PIXELS > 1) ? $clog2(CHANNELS * IMG_PIXELS) : 1,
  localparam int unsigned DW = 8 * PIX_BYTES
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_weights_loaded,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_ready,
  input  logic          i_img_consumed,
  output logic          o_wr_en,
  output logic          o_wr_bank,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_image_loaded,
  output logic          o_rd_bank,
  output logic          o_frame_err,
  output logic [1:0]    o_err_code
);

  localparam int unsigned NumBytes = CHANNELS * IMG_PIXELS * PIX_BYTES;
  localparam int unsigned BCW      = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);

  state_e         r_state, w_state_d;
  logic           w_accept, w_in_frame, w_tmo_hit, w_start, w_byte_vld;
  logic [1:0]     w_err_d, w_full_d;

  logic [BCW-1:0] r_bcnt;
  logic [TW-1:0]  r_tmo;
  logic [1:0]     r_full;
  logic [1:0]     r_err_pend;   // reason latched on entry to StErr
  logic [1:0]     r_err_code;
  logic           r_wr_bank, r_rd_bank, r_image_loaded, r_frame_err;

  assign w_accept   = i_rx_ready & i_weights_loaded;
  assign w_in_frame = (r_state == StData) || (r_state == StEnd1) || (r_state == StEnd2);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d  = r_state;
    w_start    = 1'b0;
    w_byte_vld = 1'b0;
    w_err_d    = r_err_pend;
    case (r_state)
      StIdle: begin
        if (w_accept && i_rx_data == START_MARK) begin
          if (&r_full) begin
            w_state_d = StErr;
            w_err_d   = ERR_OVR;
          end else begin
            w_state_d = StData;
            w_start   = 1'b1;
          end
        end
      end
      StData, StEnd1, StEnd2: begin
        if (!i_weights_loaded) begin
          w_state_d = StIdle;
        end else if (i_rx_ready) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (r_state == StData) begin
            w_byte_vld = 1'b1;
            if (r_bcnt == BCW'(NumBytes - 1)) w_state_d = StEnd1;
          end else if (r_state == StEnd1) begin
            if (i_rx_data == END_MARK1) begin
              w_state_d = StEnd2;
            end else begin
              w_state_d = StErr;
              w_err_d   = ERR_END;
            end
          end else begin
            if (i_rx_data == END_MARK2) begin
              w_state_d = StDone;
            end else begin
              w_state_d = StErr;
              w_err_d   = ERR_END;
            end
          end
        end else if (w_tmo_hit) begin
          w_state_d = StErr;
          w_err_d   = ERR_TMO;
        end
      end
      StDone, StErr: w_state_d = StIdle;
      default:       w_state_d = StIdle;
    endcase
  end

  // Consumption clears first so a same-cycle completion into that bank wins.
  always_comb begin
    w_full_d = r_full;
    if (i_img_consumed)     w_full_d[r_rd_bank] = 1'b0;
    if (r_state == StDone)  w_full_d[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bcnt         <= '0;
      r_tmo          <= '0;
      r_full         <= 2'b00;
      r_err_pend     <= ERR_NONE;
      r_err_code     <= ERR_NONE;
      r_wr_bank      <= 1'b0;
      r_rd_bank      <= 1'b0;
      r_image_loaded <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_image_loaded <= (r_state == StDone);
      r_frame_err    <= (r_state == StErr);
      r_err_pend     <= w_err_d;
      r_full         <= w_full_d;
      if (r_state == StErr) r_err_code <= r_err_pend;
      if (r_state == StDone) begin
        r_rd_bank <= r_wr_bank;
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_start)         r_bcnt <= '0;
      else if (w_byte_vld) r_bcnt <= r_bcnt + 1'b1;
      if (w_in_frame && !i_rx_ready) r_tmo <= r_tmo + 1'b1;
      else                           r_tmo <= '0;
    end
  end

  pix_deinterleave #(
    .CHANNELS   (CHANNELS),
    .IMG_PIXELS (IMG_PIXELS),
    .PIX_BYTES  (PIX_BYTES),
    .AW         (AW),
    .DW         (DW)
  ) u_deint (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_start),
    .i_valid (w_byte_vld),
    .i_byte  (i_rx_data),
    .o_valid (o_wr_en),
    .o_addr  (o_wr_addr),
    .o_data  (o_wr_data)
  );

  assign o_wr_bank      = r_wr_bank;
  assign o_rd_bank      = r_rd_bank;
  assign o_image_loaded = r_image_loaded;
  assign o_frame_err    = r_frame_err;
  assign o_err_code     = r_err_code;

endmodule

// File: tb/tb_image_loader_mc.sv
// Bench for image_loader_mc: a default 1-channel instance (short timeout) and a
// 3-channel, 2-byte, 4-pixel instance driven from a vector table.
module tb_image_loader_mc;

  localparam int unsigned TMO = 500;

  logic clk;
  logic rst_n;

  logic       wl_a, rdy_a, cons_a;
  logic [7:0] dat_a;
  logic       wr_en_a, wr_bank_a, il_a, rd_bank_a, fe_a;
  logic [9:0] wr_addr_a;
  logic [7:0] wr_data_a;
  logic [1:0] err_code_a;

  logic        wl_b, rdy_b, cons_b;
  logic [7:0]  dat_b;
  logic        wr_en_b, wr_bank_b, il_b, rd_bank_b, fe_b;
  logic [3:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [1:0]  err_code_b;

  image_loader_mc #(
    .TIMEOUT_CYC (TMO)
  ) dut_a (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_weights_loaded (wl_a),
    .i_rx_data        (dat_a),
    .i_rx_ready       (rdy_a),
    .i_img_consumed   (cons_a),
    .o_wr_en          (wr_en_a),
    .o_wr_bank        (wr_bank_a),
    .o_wr_addr        (wr_addr_a),
    .o_wr_data        (wr_data_a),
    .o_image_loaded   (il_a),
    .o_rd_bank        (rd_bank_a),
    .o_frame_err      (fe_a),
    .o_err_code       (err_code_a)
  );

  image_loader_mc #(
    .CHANNELS   (3),
    .IMG_PIXELS (4),
    .PIX_BYTES  (2)
  ) dut_b (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_weights_loaded (wl_b),
    .i_rx_data        (dat_b),
    .i_rx_ready       (rdy_b),
    .i_img_consumed   (cons_b),
    .o_wr_en          (wr_en_b),
    .o_wr_bank        (wr_bank_b),
    .o_wr_addr        (wr_addr_b),
    .o_wr_data        (wr_data_b),
    .o_image_loaded   (il_b),
    .o_rd_bank        (rd_bank_b),
    .o_frame_err      (fe_b),
    .o_err_code       (err_code_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state for instance A
  int   seed_a, wr_cnt_a, wr_bad_a, il_cnt_a, fe_cnt_a;
  logic exp_bank_a;
  logic mark_mode;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [3:0]  addr;
    logic [15:0] data;
  } vec_t;
  vec_t tab [12];

  logic [24:0] outs_a;
  assign outs_a = {wr_en_a, wr_bank_a, wr_addr_a, wr_data_a, il_a, rd_bank_a, fe_a, err_code_a};

  function automatic logic [7:0] pat(input int i);
    if (mark_mode && i == 100) return 8'h66;
    if (mark_mode && i == 101) return 8'hBB;
    return 8'(i + seed_a);
  endfunction

  always @(negedge clk) begin
    if (wr_en_a) begin
      if (wr_addr_a !== 10'(wr_cnt_a) || wr_data_a !== pat(wr_cnt_a) || wr_bank_a !== exp_bank_a)
        wr_bad_a++;
      wr_cnt_a++;
    end
    if (il_a) il_cnt_a++;
    if (fe_a) fe_cnt_a++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    wr_cnt_a = 0;
    wr_bad_a = 0;
    il_cnt_a = 0;
    fe_cnt_a = 0;
  endtask

  task automatic send_a(input logic [7:0] b);
    rdy_a = 1'b1;
    dat_a = b;
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rdy_b = 1'b1;
    dat_b = b;
    @(posedge clk);
    #1;
    rdy_b = 1'b0;
  endtask

  // Full frame on A; optional idle stall after payload byte stall_at.
  task automatic frame_a(input logic [7:0] t1, input logic [7:0] t2, input int stall_at,
                         input int stall_len, input bit lat_chk);
    send_a(8'h66);
    if (lat_chk) check("start byte writes nothing", wr_en_a, 1'b0);
    for (int i = 0; i < 784; i++) begin
      send_a(pat(i));
      if (lat_chk && i == 0) begin
        check("first write latency", wr_en_a, 1'b1);
        check("first write addr", wr_addr_a, 10'd0);
      end
      if (i == stall_at) tick(stall_len);
    end
    send_a(t1);
    send_a(t2);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    wl_a = 1'b0; rdy_a = 1'b0; dat_a = 8'h00; cons_a = 1'b0;
    wl_b = 1'b0; rdy_b = 1'b0; dat_b = 8'h00; cons_b = 1'b0;
    seed_a = 0; exp_bank_a = 1'b0; mark_mode = 1'b0;
    clr();

    // Sample value 0x0100*c + p, pixel-interleaved; address c*4 + p.
    tab[0]  = '{8'h00, 8'h00, 4'd0,  16'h0000};
    tab[1]  = '{8'h00, 8'h01, 4'd4,  16'h0100};
    tab[2]  = '{8'h00, 8'h02, 4'd8,  16'h0200};
    tab[3]  = '{8'h01, 8'h00, 4'd1,  16'h0001};
    tab[4]  = '{8'h01, 8'h01, 4'd5,  16'h0101};
    tab[5]  = '{8'h01, 8'h02, 4'd9,  16'h0201};
    tab[6]  = '{8'h02, 8'h00, 4'd2,  16'h0002};
    tab[7]  = '{8'h02, 8'h01, 4'd6,  16'h0102};
    tab[8]  = '{8'h02, 8'h02, 4'd10, 16'h0202};
    tab[9]  = '{8'h03, 8'h00, 4'd3,  16'h0003};
    tab[10] = '{8'h03, 8'h01, 4'd7,  16'h0103};
    tab[11] = '{8'h03, 8'h02, 4'd11, 16'h0203};

    tick(3);
    check("reset outputs a", 32'(outs_a), 32'd0);
    check("reset outputs b", {wr_en_b, wr_bank_b, wr_addr_b, wr_data_b, il_b, rd_bank_b, fe_b,
                              err_code_b}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // ---- Instance B: table-driven planar mapping
    wl_b = 1'b1;
    send_b(8'h66);
    for (int k = 0; k < 12; k++) begin
      send_b(tab[k].lo);
      check("b no write on lsb", wr_en_b, 1'b0);
      send_b(tab[k].hi);
      check("b wr_en", wr_en_b, 1'b1);
      check("b wr_addr", wr_addr_b, tab[k].addr);
      check("b wr_data", wr_data_b, tab[k].data);
    end
    send_b(8'h66);
    send_b(8'hBB);
    tick(1);
    check("b image_loaded", il_b, 1'b1);
    check("b wr_bank after", wr_bank_b, 1'b1);

    // ---- Instance A: weights low blocks everything, garbage in idle ignored
    send_a(8'h66); send_a(8'h01); send_a(8'h02);
    tick(2);
    check("weights low writes", wr_cnt_a, 0);
    wl_a = 1'b1;
    send_a(8'h00); send_a(8'h12); send_a(8'hBB);
    tick(2);

    // Frame 1: bank 0
    seed_a = 0; exp_bank_a = 1'b0; clr();
    frame_a(8'h66, 8'hBB, -1, 0, 1'b1);
    check("f1 no pulse yet", il_a, 1'b0);
    tick(1);
    check("f1 image_loaded", il_a, 1'b1);
    check("f1 rd_bank", rd_bank_a, 1'b0);
    check("f1 wr_bank", wr_bank_a, 1'b1);
    tick(2);
    check("f1 writes", wr_cnt_a, 784);
    check("f1 bad writes", wr_bad_a, 0);
    check("f1 pulse count", il_cnt_a, 1);

    // Frame 2: markers inside payload, then bad trailer
    seed_a = 7; mark_mode = 1'b1; exp_bank_a = 1'b1; clr();
    frame_a(8'h66, 8'h00, -1, 0, 1'b0);
    tick(1);
    check("bad end frame_err", fe_a, 1'b1);
    check("bad end err_code", err_code_a, 2'd1);
    check("bad end rd_bank", rd_bank_a, 1'b0);
    check("bad end wr_bank", wr_bank_a, 1'b1);
    tick(2);
    check("marker payload writes", wr_cnt_a, 784);
    check("marker payload bad", wr_bad_a, 0);
    check("bad end no load", il_cnt_a, 0);
    mark_mode = 1'b0;

    // Timeout after payload byte 300
    tick(2);
    seed_a = 3; clr();
    send_a(8'h66);
    for (int i = 0; i <= 300; i++) send_a(pat(i));
    n = 0;
    while (n < 4 * TMO && fe_a !== 1'b1) begin
      tick(1);
      n++;
    end
    check("timeout latency", n, TMO + 1);
    check("timeout err_code", err_code_a, 2'd2);
    check("timeout writes", wr_cnt_a, 301);
    check("timeout wr_bank", wr_bank_a, 1'b1);

    // Frame 3: stall one cycle short of the timeout, loads into the same bank
    tick(2);
    seed_a = 9; clr();
    frame_a(8'h66, 8'hBB, 300, TMO - 1, 1'b0);
    tick(1);
    check("f3 image_loaded", il_a, 1'b1);
    check("f3 rd_bank", rd_bank_a, 1'b1);
    tick(2);
    check("f3 writes", wr_cnt_a, 784);
    check("f3 bad writes", wr_bad_a, 0);
    check("f3 no error", fe_cnt_a, 0);
    check("f3 wr_bank", wr_bank_a, 1'b0);

    // Both banks full -> overrun
    tick(2);
    clr();
    send_a(8'h66);
    tick(1);
    check("overrun frame_err", fe_a, 1'b1);
    check("overrun err_code", err_code_a, 2'd3);
    tick(2);
    check("overrun writes", wr_cnt_a, 0);

    // Release, then frame 4 into bank 0
    cons_a = 1'b1;
    tick(1);
    cons_a = 1'b0;
    tick(1);
    seed_a = 11; exp_bank_a = 1'b0; clr();
    frame_a(8'h66, 8'hBB, -1, 0, 1'b0);
    tick(1);
    check("f4 image_loaded", il_a, 1'b1);
    check("f4 rd_bank", rd_bank_a, 1'b0);
    tick(2);
    check("f4 writes", wr_cnt_a, 784);
    check("f4 bad writes", wr_bad_a, 0);

    // Reset at payload byte 400
    seed_a = 0; exp_bank_a = 1'b1; clr();
    send_a(8'h66);
    for (int i = 0; i < 400; i++) send_a(pat(i));
    check("pre-reset wr_en", wr_en_a, 1'b1);
    rst_n = 1'b0;
    tick(1);
    check("mid-frame reset outputs", 32'(outs_a), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // weights_loaded drops mid-frame: silent abort
    seed_a = 5; exp_bank_a = 1'b0; clr();
    send_a(8'h66);
    for (int i = 0; i < 50; i++) send_a(pat(i));
    wl_a = 1'b0;
    tick(2);
    wl_a = 1'b1;
    tick(2);
    check("silent abort no frame_err", fe_cnt_a, 0);
    check("silent abort writes", wr_cnt_a, 50);

    // Frame 5 into bank 0 with a release of the same bank in its DONE cycle
    seed_a = 13; clr();
    frame_a(8'h66, 8'hBB, -1, 0, 1'b0);
    cons_a = 1'b1;
    tick(1);
    cons_a = 1'b0;
    check("f5 image_loaded", il_a, 1'b1);
    tick(2);
    check("f5 writes", wr_cnt_a, 784);
    check("f5 bad writes", wr_bad_a, 0);

    seed_a = 17; exp_bank_a = 1'b1; clr();
    frame_a(8'h66, 8'hBB, -1, 0, 1'b0);
    tick(3);
    check("f6 pulse count", il_cnt_a, 1);
    check("f6 writes", wr_cnt_a, 784);

    // Bank 0 must still be full (set beat the clear), so this start overruns
    clr();
    send_a(8'h66);
    tick(1);
    check("set-wins frame_err", fe_a, 1'b1);
    check("set-wins err_code", err_code_a, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
